dmem_line_responder: RTL and testbench
======================================

// Module: dmem_line_responder
// PURPOSE
//  Memory-side responder for the processor's data-memory stage. Accepts one 128-bit line
//  request (read or word-masked write) per transaction over a valid/ready handshake.
//  Models fixed-latency backing storage and returns a registered response.
//  Drives busy so the hazard unit can hold the mem stage while a transaction is outstanding.
// PARAMETERS
//  ADDR_W      36   width of req_addr (line address, one line per index)
//  LINE_W      128  line width; four 32-bit words, word i = bits [32*i+31:32*i]
//  DEPTH_LOG2  10   log2 of number of lines in storage (1024 lines)
//  LATENCY     4    access latency in cycles, legal range 1..255
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       reset, asynchronous, active-low
//  req_valid   in   1       request present
//  req_ready   out  1       responder can accept; high only in IDLE
//  req_write   in   1       1 = write, 0 = read
//  req_addr    in   ADDR_W  line address
//  req_wdata   in   LINE_W  write data
//  req_wmask   in   4       per-word write enable, bit i -> word i
//  resp_valid  out  1       response present, held until accepted
//  resp_ready  in   1       requester accepts response
//  resp_rdata  out  LINE_W  line contents after the access; 0 on error
//  resp_err    out  1       address out of range; qualified by resp_valid
//  busy        out  1       transaction outstanding (state != IDLE)
//  acc_count   out  16      completed in-range accesses, wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0,
//   acc_count=0, latency counter=0. Storage contents are not reset.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE: req_valid & req_ready = accept. Capture addr, write, wdata, wmask.
//   Load cnt=LATENCY-1. Go to WAIT.
//  WAIT: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the access on this edge:
//   - In range (req_addr[ADDR_W-1:DEPTH_LOG2]==0):
//     - write: update the words selected by wmask; unselected words are unchanged.
//     - read and write: resp_rdata <= resulting line; resp_err <= 0; acc_count++.
//   - Out of range: no storage update, resp_rdata <= 0, resp_err <= 1, acc_count unchanged.
//   - Then go to RESP with resp_valid <= 1.
//  Timing: first cycle with resp_valid high = accept cycle + LATENCY + 1.
//   Example: LATENCY=4, accepted in cycle 10 -> resp_valid first high in cycle 15.
//  RESP: resp_valid, resp_rdata and resp_err are held stable until resp_valid & resp_ready.
//   On that handshake: go to IDLE, clear resp_valid. resp_rdata keeps its last value.
//  req_ready is combinational from state (IDLE only). There is no accept in the same cycle as
//   a response handshake, so the minimum request-to-request spacing is LATENCY+2 cycles.
//  req_valid outside IDLE is ignored. Request inputs need not stay stable after accept.
//  wmask=0 on a write: no storage change; completes as a read (counted, rdata = current line).
//  Storage write and read of the same line in one access: rdata reflects the new data.
//  rst_n asserted mid-transaction: FSM returns to IDLE at once and the response is dropped.
//   A write whose access edge has not occurred is not committed.
//  busy == (state != IDLE), derived from registered state only.
// TESTING
//  1. Reset release, no traffic -> req_ready=1, busy=0, resp_valid=0, acc_count=0 for 20 cycles.
//  2. LATENCY=4: write addr 0x5, wdata={4{32'hA5A5_0001}}, wmask=4'hF, accepted cycle 10
//     -> resp_valid first high cycle 15, resp_err=0. Then read addr 0x5 -> rdata={4{32'hA5A5_0001}}.
//  3. Partial write to addr 0x5: wmask=4'b0100, word2=32'hDEAD_BEEF -> read returns word2=DEADBEEF,
//     all other words A5A50001; acc_count=3 after the three transactions.
//  4. Read addr 36'h4_0000_0000 (out of range) -> resp_err=1, rdata=0, acc_count unchanged.
//  5. Hold resp_ready=0 for 6 cycles in RESP with req_valid=1 -> resp held stable, req_ready=0,
//     busy=1. Release resp_ready -> IDLE next cycle; the next request is accepted.
//  6. Assert rst_n=0 during WAIT of a write to addr 0x9 -> outputs return to reset values
//     immediately. A later read of 0x9 returns the pre-write data.

Source files
------------

// File: rtl/dmem_line_responder.sv
// Memory-side responder for the data-memory stage: one 128-bit line read or
// word-masked write per transaction, fixed access latency, registered response.
module dmem_line_responder #(
    parameter int ADDR_W     = 36,
    parameter int LINE_W     = 128,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    input  logic [3:0]        req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [LINE_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [15:0]       acc_count
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; valid is held with its payload stable until that edge.

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_write;
    logic [LINE_W-1:0] cap_wdata;
    logic [3:0]        cap_wmask;

    logic [LINE_W-1:0] mem [0:DEPTH-1];

    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  access;
    logic [LINE_W-1:0]     merged;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign in_range  = (cap_addr[ADDR_W-1:DEPTH_LOG2] == '0);
    assign idx       = cap_addr[DEPTH_LOG2-1:0];
    assign access    = (state == ST_WAIT) && (cnt == 8'd0);

    // Line as it stands after this access; a read or a zero mask leaves it unchanged.
    always_comb begin
        merged = mem[idx];
        if (cap_write) begin
            for (int w = 0; w < 4; w++) begin
                if (cap_wmask[w]) merged[32*w +: 32] = cap_wdata[32*w +: 32];
            end
        end
    end

    // Storage is not reset; writes only land on the access edge of an in-range write.
    always_ff @(posedge clk) begin
        if (access && in_range && cap_write) mem[idx] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            cap_addr   <= '0;
            cap_write  <= 1'b0;
            cap_wdata  <= '0;
            cap_wmask  <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            acc_count  <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_addr  <= req_addr;
                        cap_write <= req_write;
                        cap_wdata <= req_wdata;
                        cap_wmask <= req_wmask;
                        cnt       <= CNT_INIT;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        if (in_range) begin
                            resp_rdata <= merged;
                            resp_err   <= 1'b0;
                            acc_count  <= acc_count + 16'd1;
                        end else begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed plus randomized checks of dmem_line_responder against a line-array
// model that applies masks word by word and counts in-range accesses.
module tb_dmem_line_responder;

    localparam int ADDR_W  = 36;
    localparam int LINE_W  = 128;
    localparam int LATENCY = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [LINE_W-1:0] req_wdata = '0;
    logic [3:0]        req_wmask = 4'd0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [LINE_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;
    logic [15:0]       acc_count;

    int vectors = 0;
    int miscompares = 0;

    logic [LINE_W-1:0] model_mem [int];
    logic [15:0]       model_cnt = 16'd0;

    dmem_line_responder #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH_LOG2(10), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .acc_count(acc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called just after a negedge while idle; returns just after the negedge following accept.
    task automatic issue_req(input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [LINE_W-1:0] wdata, input logic [3:0] wmask);
        chk("req_ready_idle", LINE_W'(req_ready), 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = $urandom_range(0, 1); req_addr = ADDR_W'($urandom);
        req_wdata = rnd_line(); req_wmask = 4'($urandom);
    endtask

    task automatic wait_resp();
        int k = 1;
        while (!resp_valid && k < 300) begin
            chk("busy_wait", LINE_W'({busy, req_ready}), 2'b10);
            @(negedge clk);
            k++;
        end
        chk("resp_latency", LINE_W'(k), LATENCY + 1);
    endtask

    task automatic finish_resp(input int hold);
        for (int i = 0; i < hold; i++) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("idle_after_hs", LINE_W'({resp_valid, busy, req_ready}), 3'b001);
    endtask

    // Expected outcome of one access, computed from the model.
    task automatic expect_access(input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [LINE_W-1:0] wdata, input logic [3:0] wmask,
                                 output logic [LINE_W-1:0] exp_line, output logic exp_err);
        int ix;
        if (addr >= 1024) begin
            exp_line = '0;
            exp_err  = 1'b1;
        end else begin
            ix = int'(addr);
            exp_line = model_mem.exists(ix) ? model_mem[ix] : 'x;
            if (wr) begin
                for (int w = 0; w < 4; w++)
                    if (wmask[w]) exp_line[32*w +: 32] = wdata[32*w +: 32];
                model_mem[ix] = exp_line;
            end
            exp_err = 1'b0;
            model_cnt = model_cnt + 16'd1;
        end
    endtask

    task automatic do_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [LINE_W-1:0] wdata, input logic [3:0] wmask, input int hold);
        logic [LINE_W-1:0] exp_line;
        logic exp_err;
        expect_access(wr, addr, wdata, wmask, exp_line, exp_err);
        issue_req(wr, addr, wdata, wmask);
        wait_resp();
        chk("resp_err", LINE_W'(resp_err), LINE_W'(exp_err));
        chk("resp_rdata", resp_rdata, exp_line);
        chk("acc_count", LINE_W'(acc_count), LINE_W'(model_cnt));
        finish_resp(hold);
    endtask

    initial begin
        logic [LINE_W-1:0] line_a, line_p, held_rdata, exp_line;
        logic held_err, exp_err;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rdata", resp_rdata, '0);
        chk("rst_err", LINE_W'(resp_err), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_flags", LINE_W'({req_ready, busy, resp_valid}), 3'b100);
            chk("idle_count", LINE_W'(acc_count), 0);
        end

        // Full write then read of line 5
        line_a = {4{32'hA5A5_0001}};
        do_txn(1'b1, 36'h5, line_a, 4'hF, 0);
        do_txn(1'b0, 36'h5, rnd_line(), 4'h0, 1);

        // Word-2 partial write; other words of wdata are junk that must be masked off
        line_p = rnd_line();
        line_p[95:64] = 32'hDEAD_BEEF;
        do_txn(1'b1, 36'h5, line_p, 4'b0100, 0);
        chk("count_after_three", LINE_W'(acc_count), 3);
        do_txn(1'b0, 36'h5, '0, 4'h0, 0);
        chk("partial_line", resp_rdata,
            {32'hA5A5_0001, 32'hDEAD_BEEF, 32'hA5A5_0001, 32'hA5A5_0001});

        // Write with empty mask behaves as a counted read
        do_txn(1'b1, 36'h5, rnd_line(), 4'h0, 0);

        // Out of range
        do_txn(1'b0, 36'h4_0000_0000, '0, 4'h0, 0);
        do_txn(1'b1, 36'hF_FFFF_FC05, rnd_line(), 4'hF, 0);

        // Back-pressure on the response while a new request is waiting
        expect_access(1'b0, 36'h5, '0, 4'h0, exp_line, exp_err);
        issue_req(1'b0, 36'h5, '0, 4'h0);
        wait_resp();
        held_rdata = resp_rdata;
        held_err = resp_err;
        chk("bp_rdata", held_rdata, exp_line);
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 36'h7; req_wdata = rnd_line(); req_wmask = 4'hF;
            @(negedge clk);
            chk("bp_flags", LINE_W'({resp_valid, req_ready, busy}), 3'b101);
            chk("bp_hold_rdata", resp_rdata, held_rdata);
            chk("bp_hold_err", LINE_W'(resp_err), LINE_W'(held_err));
        end
        req_valid = 1'b0;
        finish_resp(0);
        do_txn(1'b0, 36'h5, '0, 4'h0, 0);

        // Reset during the wait of a write: nothing committed, outputs back to reset values
        do_txn(1'b1, 36'h9, rnd_line(), 4'hF, 0);
        issue_req(1'b1, 36'h9, rnd_line(), 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", LINE_W'({req_ready, busy, resp_valid, resp_err}), 4'b1000);
        chk("mid_rst_rdata", resp_rdata, '0);
        chk("mid_rst_count", LINE_W'(acc_count), 0);
        model_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 36'h9, '0, 4'h0, 0);

        // Randomized traffic over a small pre-initialised window plus out-of-range hits
        for (int a = 0; a < 16; a++) do_txn(1'b1, ADDR_W'(a), rnd_line(), 4'hF, 0);
        for (int t = 0; t < 40; t++) begin
            logic [ADDR_W-1:0] addr;
            if ($urandom_range(0, 5) == 0)
                addr = {26'($urandom_range(1, 1 << 20)), 10'($urandom_range(0, 1023))};
            else
                addr = ADDR_W'($urandom_range(0, 15));
            do_txn(1'($urandom_range(0, 1)), addr, rnd_line(), 4'($urandom), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
